// File: rtl/kosei_source_arbiter.sv
// Input-source arbiter for the Kosei audio core: tracks live PCM sources, selects one
// (auto priority or manual), and inserts a muted run-in after each switch when
// KOSEI_SRC_ARB_MUTE_EN is defined.
module kosei_source_arbiter #(
    parameter int unsigned NSRC         = 4,
    parameter int unsigned DW           = 24,
    parameter int unsigned MUTE_FRAMES  = 16,
    parameter int unsigned LOSS_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC-1:0]    src_valid,
    input  logic [NSRC*DW-1:0] src_l,
    input  logic [NSRC*DW-1:0] src_r,
    output logic [NSRC-1:0]    src_ready,
    input  logic               cfg_manual,
    input  logic [1:0]         cfg_sel,
    output logic               out_valid,
    output logic [DW-1:0]      out_l,
    output logic [DW-1:0]      out_r,
    input  logic               out_ready,
    output logic [1:0]         out_src,
    output logic [NSRC-1:0]    src_active,
    output logic               switch_pulse
);

    localparam int unsigned CW = $clog2(LOSS_TIMEOUT + 1);
    localparam int unsigned SW = 2;
`ifdef KOSEI_SRC_ARB_MUTE_EN
    localparam int unsigned MW = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUTE = 2'd1,
        ST_PLAY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd2
    } state_t;
`endif

    state_t          state, state_nxt;
    logic [SW-1:0]   sel, sel_nxt;
    logic            pulse_nxt;
    logic            out_valid_nxt;
    logic [DW-1:0]   out_l_nxt, out_r_nxt;
    logic [CW-1:0]   act_cnt     [NSRC];
    logic [CW-1:0]   act_cnt_nxt [NSRC];
    logic [NSRC-1:0] active_nxt;
    logic            tgt_vld;
    logic [SW-1:0]   tgt_idx;
    logic            fire;
    logic [DW-1:0]   sel_l, sel_r;
`ifdef KOSEI_SRC_ARB_MUTE_EN
    logic [MW-1:0]   mute_cnt, mute_nxt;
`endif

    // Per-source loss-of-signal counters
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            act_cnt_nxt[i] = act_cnt[i];
            if (src_valid[i]) begin
                act_cnt_nxt[i] = CW'(LOSS_TIMEOUT);
            end else if (act_cnt[i] != '0) begin
                act_cnt_nxt[i] = act_cnt[i] - CW'(1);
            end
            active_nxt[i] = (act_cnt_nxt[i] != '0);
        end
    end

    // Selection target: manual override or lowest active index
    always_comb begin
        tgt_vld = 1'b0;
        tgt_idx = '0;
        if (cfg_manual) begin
            if ((32'(cfg_sel) < NSRC) && src_active[cfg_sel]) begin
                tgt_vld = 1'b1;
                tgt_idx = cfg_sel;
            end
        end else begin
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (src_active[i]) begin
                    tgt_vld = 1'b1;
                    tgt_idx = SW'(i);
                end
            end
        end
    end

    // Only the selected source is back-pressured; everyone else is drained
    always_comb begin
        src_ready = '1;
        if (state != ST_IDLE) begin
            src_ready[sel] = !out_valid || out_ready;
        end
    end

    assign sel_l = src_l[int'(sel)*DW +: DW];
    assign sel_r = src_r[int'(sel)*DW +: DW];
    assign fire  = (state != ST_IDLE) && src_valid[sel] && src_ready[sel];

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        pulse_nxt     = 1'b0;
        out_valid_nxt = out_valid && !out_ready;
        out_l_nxt     = out_l;
        out_r_nxt     = out_r;
`ifdef KOSEI_SRC_ARB_MUTE_EN
        mute_nxt      = mute_cnt;
`endif

        if (fire) begin
            out_valid_nxt = 1'b1;
            out_l_nxt     = sel_l;
            out_r_nxt     = sel_r;
`ifdef KOSEI_SRC_ARB_MUTE_EN
            if (state == ST_MUTE) begin
                out_l_nxt = '0;
                out_r_nxt = '0;
            end
`endif
        end

        if (state == ST_IDLE) begin
            if (tgt_vld) begin
                sel_nxt   = tgt_idx;
                pulse_nxt = 1'b1;
                state_nxt = ST_PLAY;
`ifdef KOSEI_SRC_ARB_MUTE_EN
                mute_nxt  = MW'(MUTE_FRAMES);
                if (MUTE_FRAMES != 0) state_nxt = ST_MUTE;
`endif
            end
        end else if (!tgt_vld) begin
            state_nxt = ST_IDLE;
            sel_nxt   = '0;
        end else if (tgt_idx != sel) begin
            // Re-target wins over mute completion in the same cycle
            sel_nxt   = tgt_idx;
            pulse_nxt = 1'b1;
            state_nxt = ST_PLAY;
`ifdef KOSEI_SRC_ARB_MUTE_EN
            mute_nxt  = MW'(MUTE_FRAMES);
            if (MUTE_FRAMES != 0) state_nxt = ST_MUTE;
        end else if ((state == ST_MUTE) && fire) begin
            mute_nxt = mute_cnt - MW'(1);
            if (mute_cnt == MW'(1)) state_nxt = ST_PLAY;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            sel          <= '0;
            switch_pulse <= 1'b0;
            out_valid    <= 1'b0;
            out_l        <= '0;
            out_r        <= '0;
            src_active   <= '0;
            for (int i = 0; i < NSRC; i++) act_cnt[i] <= '0;
`ifdef KOSEI_SRC_ARB_MUTE_EN
            mute_cnt     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            switch_pulse <= pulse_nxt;
            out_valid    <= out_valid_nxt;
            out_l        <= out_l_nxt;
            out_r        <= out_r_nxt;
            src_active   <= active_nxt;
            for (int i = 0; i < NSRC; i++) act_cnt[i] <= act_cnt_nxt[i];
`ifdef KOSEI_SRC_ARB_MUTE_EN
            mute_cnt     <= mute_nxt;
`endif
        end
    end

    assign out_src = sel;

endmodule
